// File: rtl/imm_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and register read.
interface imm_decode_stage_if #(
  parameter int unsigned XLEN = 32
);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;
  logic            out_illegal;
  logic [31:0]     out_instr;
  logic [XLEN-1:0] out_pc;

  // Driver side: produces instructions and consumes decoded results.
  modport master (
    output flush,
    output in_valid,
    output in_instr,
    output in_pc,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_imm,
    input  out_fmt,
    input  out_illegal,
    input  out_instr,
    input  out_pc
  );

  // Stage side.
  modport slave (
    input  flush,
    input  in_valid,
    input  in_instr,
    input  in_pc,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_imm,
    output out_fmt,
    output out_illegal,
    output out_instr,
    output out_pc
  );

endinterface

// File: rtl/imm_decode_stage.sv
// Instruction-format decode and immediate extraction with a 2-entry skid buffer.
// Decode happens on the input side; the buffered head entry drives the outputs
// straight from flops, and in_ready depends only on registered occupancy and rst.
module imm_decode_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  imm_decode_stage_if.slave bus
);

  localparam int unsigned SHAMT_W = (XLEN == 64) ? 6 : 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_e;

  state_e state_q, state_d;
  entry_t head_q, head_d;
  entry_t tail_q, tail_d;

  logic [31:0]     ins_c;
  logic [6:0]      opc_c;
  logic [2:0]      funct3_c;
  logic [XLEN-1:0] dec_imm_c;
  logic [2:0]      dec_fmt_c;
  logic            dec_illegal_c;
  entry_t          new_entry_c;
  logic            in_ready_c;
  logic            out_valid_c;
  logic            accept_c;
  logic            drain_c;

  assign ins_c    = bus.in_instr;
  assign opc_c    = ins_c[6:0];
  assign funct3_c = ins_c[14:12];

  // Classify the incoming opcode and assemble its sign/zero-extended immediate.
  always_comb begin
    dec_imm_c     = '0;
    dec_fmt_c     = FMT_R;
    dec_illegal_c = 1'b0;
    case (opc_c)
      OP_LOAD, OP_MISC, OP_JALR, OP_SYSTEM: begin
        dec_fmt_c = FMT_I;
        dec_imm_c = XLEN'($signed(ins_c[31:20]));
      end
      OP_IMM: begin
        dec_fmt_c = FMT_I;
        // Shifts carry an unsigned shamt; upper bits hold funct7, not immediate.
        if (funct3_c == 3'b001 || funct3_c == 3'b101) begin
          dec_imm_c = XLEN'(ins_c[20 +: SHAMT_W]);
        end else begin
          dec_imm_c = XLEN'($signed(ins_c[31:20]));
        end
      end
      OP_STORE: begin
        dec_fmt_c = FMT_S;
        dec_imm_c = XLEN'($signed({ins_c[31:25], ins_c[11:7]}));
      end
      OP_BRANCH: begin
        dec_fmt_c = FMT_B;
        dec_imm_c = XLEN'($signed({ins_c[31], ins_c[7], ins_c[30:25], ins_c[11:8], 1'b0}));
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt_c = FMT_U;
        dec_imm_c = XLEN'($signed({ins_c[31:12], 12'b0}));
      end
      OP_JAL: begin
        dec_fmt_c = FMT_J;
        dec_imm_c = XLEN'($signed({ins_c[31], ins_c[19:12], ins_c[20], ins_c[30:21], 1'b0}));
      end
      OP_OP: begin
        dec_fmt_c = FMT_R;
      end
      default: begin
        // Unknown opcodes still flow through so the pipeline can trap on them.
        dec_illegal_c = 1'b1;
      end
    endcase
  end

  // Bundle decode result with the pass-through fields for buffering.
  always_comb begin
    new_entry_c         = '0;
    new_entry_c.imm     = dec_imm_c;
    new_entry_c.fmt     = dec_fmt_c;
    new_entry_c.illegal = dec_illegal_c;
    new_entry_c.instr   = ins_c;
    new_entry_c.pc      = bus.in_pc;
  end

  assign in_ready_c  = (state_q != ST_TWO) && !rst;
  assign out_valid_c = (state_q != ST_EMPTY);
  assign accept_c    = bus.in_valid && in_ready_c && !bus.flush;
  assign drain_c     = out_valid_c && bus.out_ready;

  // Occupancy next-state and buffer entry updates; flush empties and zeroes.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    if (bus.flush) begin
      state_d = ST_EMPTY;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept_c) begin
            state_d = ST_ONE;
            head_d  = new_entry_c;
          end
        end
        ST_ONE: begin
          if (accept_c && drain_c) begin
            head_d = new_entry_c;
          end else if (accept_c) begin
            state_d = ST_TWO;
            tail_d  = new_entry_c;
          end else if (drain_c) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain_c) begin
            state_d = ST_ONE;
            head_d  = tail_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          head_d  = '0;
          tail_d  = '0;
        end
      endcase
    end
  end

  // State and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_c;
  assign bus.out_imm     = head_q.imm;
  assign bus.out_fmt     = head_q.fmt;
  assign bus.out_illegal = head_q.illegal;
  assign bus.out_instr   = head_q.instr;
  assign bus.out_pc      = head_q.pc;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: directed format vectors (XLEN 32 and 64),
// backpressure, flush, reset, then randomized traffic against a queue model.
module tb_imm_decode_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  imm_decode_stage_if #(.XLEN(32)) b32 ();
  imm_decode_stage_if #(.XLEN(64)) b64 ();

  imm_decode_stage #(.XLEN(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_decode_stage #(.XLEN(64)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  exp_t q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
    return v;
  endfunction

  function automatic longint fld(input logic [31:0] ins, input int lo, input int width);
    return (longint'(ins) >> lo) % (longint'(1) << width);
  endfunction

  // Reference decode from the format tables, using integer field arithmetic.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [63:0] pc, input int xlen);
    exp_t   e;
    longint v;
    int     f3;
    v  = 0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    f3 = int'(fld(ins, 12, 3));
    case (fld(ins, 0, 7))
      7'h03, 7'h0F, 7'h67, 7'h73: begin e.fmt = 3'd1; v = sx(fld(ins, 20, 12), 12); end
      7'h13: begin
        e.fmt = 3'd1;
        if (f3 == 1 || f3 == 5) v = fld(ins, 20, (xlen == 64) ? 6 : 5);
        else v = sx(fld(ins, 20, 12), 12);
      end
      7'h23: begin e.fmt = 3'd2; v = sx(fld(ins, 25, 7) * 32 + fld(ins, 7, 5), 12); end
      7'h63: begin
        e.fmt = 3'd3;
        v = sx(fld(ins, 31, 1) * 4096 + fld(ins, 7, 1) * 2048 + fld(ins, 25, 6) * 32 + fld(ins, 8, 4) * 2, 13);
      end
      7'h37, 7'h17: begin e.fmt = 3'd4; v = sx(fld(ins, 12, 20) * 4096, 32); end
      7'h6F: begin
        e.fmt = 3'd5;
        v = sx(fld(ins, 31, 1) * (1 << 20) + fld(ins, 12, 8) * 4096 + fld(ins, 20, 1) * 2048 + fld(ins, 21, 10) * 2, 21);
      end
      7'h33: e.fmt = 3'd0;
      default: e.ill = 1'b1;
    endcase
    e.imm   = (xlen == 32) ? (64'(v) & 64'hFFFF_FFFF) : 64'(v);
    e.instr = ins;
    e.pc    = pc;
    return e;
  endfunction

  // One directed 32-bit decode: accept, check the head, then drain it.
  task automatic fmt32(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] eimm, input logic [2:0] efmt, input logic eill);
    b32.in_valid = 1'b1; b32.in_instr = ins; b32.in_pc = pc; b32.out_ready = 1'b0;
    @(posedge clk); #1;
    b32.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(b32.out_valid), 64'd1);
    chk({tag, "_imm"},   64'(b32.out_imm), 64'(eimm));
    chk({tag, "_fmt"},   64'(b32.out_fmt), 64'(efmt));
    chk({tag, "_ill"},   64'(b32.out_illegal), 64'(eill));
    chk({tag, "_instr"}, 64'(b32.out_instr), 64'(ins));
    chk({tag, "_pc"},    64'(b32.out_pc), 64'(pc));
    b32.out_ready = 1'b1;
    @(posedge clk); #1;
    b32.out_ready = 1'b0;
    chk({tag, "_drained"}, 64'(b32.out_valid), 64'd0);
  endtask

  task automatic fmt64(input string tag, input logic [31:0] ins, input logic [63:0] eimm);
    b64.in_valid = 1'b1; b64.in_instr = ins; b64.in_pc = 64'h8000_0000_0000_0100; b64.out_ready = 1'b1;
    @(posedge clk); #1;
    b64.in_valid = 1'b0;
    chk({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
    chk({tag, "_imm"},   b64.out_imm, eimm);
    @(posedge clk); #1;
    chk({tag, "_drained"}, 64'(b64.out_valid), 64'd0);
  endtask

  logic [31:0] bp_i [5];
  logic [31:0] bp_p [5];
  logic [6:0]  ops  [11];
  logic [31:0] r, ins;
  logic [6:0]  op;
  logic        acc, dr;
  int          sent, got, accepted, cyc;

  initial begin
    ops = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
    rst = 1'b1;
    b32.flush = 1'b0; b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_pc = '0; b32.out_ready = 1'b0;
    b64.flush = 1'b0; b64.in_valid = 1'b0; b64.in_instr = '0; b64.in_pc = '0; b64.out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(b32.in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rst_out_valid", 64'(b32.out_valid), 64'd0);
    chk("rst_out_imm", 64'(b32.out_imm), 64'd0);
    chk("rst_out_instr", 64'(b32.out_instr), 64'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(b32.in_ready), 64'd1);

    // Format vectors, XLEN=32
    fmt32("lw",   32'hFFC1_2083, 32'h0000_1000, 32'hFFFF_FFFC, 3'd1, 1'b0);
    fmt32("sw",   32'hFE11_2E23, 32'h0000_1004, 32'hFFFF_FFFC, 3'd2, 1'b0);
    fmt32("beq",  32'hFE00_0CE3, 32'h0000_1008, 32'hFFFF_FFF8, 3'd3, 1'b0);
    fmt32("lui",  32'h1234_52B7, 32'h0000_100C, 32'h1234_5000, 3'd4, 1'b0);
    fmt32("jal",  32'h0010_00EF, 32'h0000_1010, 32'h0000_0800, 3'd5, 1'b0);
    fmt32("srai", 32'h4031_5093, 32'h0000_1014, 32'h0000_0003, 3'd1, 1'b0);
    fmt32("ill",  32'h0000_007F, 32'h0000_1018, 32'h0000_0000, 3'd0, 1'b1);

    // XLEN=64 extension
    fmt64("lui64",  32'h8000_02B7, 64'hFFFF_FFFF_8000_0000);
    fmt64("slli63", 32'h03F1_1093, 64'd63);

    // Backpressure: 5 instructions against a 4-cycle stall
    for (int i = 0; i < 5; i++) begin
      bp_i[i] = 32'h0000_0093 | (32'(i + 1) << 20);
      bp_p[i] = 32'h0000_2000 + 32'(4 * i);
    end
    sent = 0; got = 0;
    b32.out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      b32.in_valid = 1'b1; b32.in_instr = bp_i[sent]; b32.in_pc = bp_p[sent];
      acc = b32.in_ready;
      @(posedge clk); #1;
      if (acc) sent++;
      if (c >= 1) begin
        chk("bp_hold_instr", 64'(b32.out_instr), 64'(bp_i[0]));
        chk("bp_hold_pc", 64'(b32.out_pc), 64'(bp_p[0]));
        chk("bp_hold_imm", 64'(b32.out_imm), 64'd1);
      end
    end
    chk("bp_sent_two", 64'(sent), 64'd2);
    chk("bp_in_ready_low", 64'(b32.in_ready), 64'd0);
    b32.out_ready = 1'b1;
    for (int k = 0; k < 20 && got < 5; k++) begin
      b32.in_valid = (sent < 5);
      if (sent < 5) begin b32.in_instr = bp_i[sent]; b32.in_pc = bp_p[sent]; end
      acc = b32.in_valid && b32.in_ready;
      dr  = b32.out_valid && b32.out_ready;
      if (dr) begin
        chk("bp_order_instr", 64'(b32.out_instr), 64'(bp_i[got]));
        chk("bp_order_pc", 64'(b32.out_pc), 64'(bp_p[got]));
      end
      @(posedge clk); #1;
      if (acc) sent++;
      if (dr) got++;
    end
    b32.in_valid = 1'b0;
    chk("bp_all_out", 64'(got), 64'd5);
    chk("bp_empty", 64'(b32.out_valid), 64'd0);

    // Flush while full with a valid input pending
    b32.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      b32.in_valid = 1'b1; b32.in_instr = bp_i[i]; b32.in_pc = bp_p[i];
      @(posedge clk); #1;
    end
    chk("fl_full", 64'(b32.in_ready), 64'd0);
    b32.in_instr = 32'h0050_0093; b32.flush = 1'b1;
    @(posedge clk); #1;
    b32.flush = 1'b0; b32.in_valid = 1'b0;
    chk("fl_out_valid", 64'(b32.out_valid), 64'd0);
    chk("fl_in_ready", 64'(b32.in_ready), 64'd1);
    chk("fl_out_instr", 64'(b32.out_instr), 64'd0);
    b32.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("fl_not_delivered", 64'(b32.out_valid), 64'd0);
    end

    // Reset mid-stream
    b32.out_ready = 1'b0;
    b32.in_valid = 1'b1; b32.in_instr = 32'hFFC1_2083; b32.in_pc = 32'h0000_3000;
    @(posedge clk); #1;
    chk("mr_loaded", 64'(b32.out_valid), 64'd1);
    b32.in_instr = 32'h1234_52B7; rst = 1'b1;
    @(posedge clk); #1;
    chk("mr_valid", 64'(b32.out_valid), 64'd0);
    chk("mr_imm", 64'(b32.out_imm), 64'd0);
    chk("mr_fmt", 64'(b32.out_fmt), 64'd0);
    chk("mr_ill", 64'(b32.out_illegal), 64'd0);
    chk("mr_instr", 64'(b32.out_instr), 64'd0);
    chk("mr_pc", 64'(b32.out_pc), 64'd0);
    chk("mr_in_ready", 64'(b32.in_ready), 64'd0);
    rst = 1'b0; b32.in_valid = 1'b0;
    #1;
    chk("mr_in_ready_after", 64'(b32.in_ready), 64'd1);

    // Randomized valid/ready/flush traffic against the queue model
    accepted = 0; cyc = 0;
    while (accepted < 10000 && cyc < 60000) begin
      r = $urandom();
      if ($urandom_range(0, 9) == 0) op = r[6:0];
      else op = ops[$urandom_range(0, 10)];
      ins = {r[31:7], op};
      b32.in_valid  = ($urandom_range(0, 9) < 7);
      b32.in_instr  = ins;
      b32.in_pc     = $urandom();
      b32.out_ready = ($urandom_range(0, 9) < 7);
      b32.flush     = ($urandom_range(0, 63) == 0);
      #1;
      chk("rnd_out_valid", 64'(b32.out_valid), 64'(q.size() != 0));
      chk("rnd_in_ready", 64'(b32.in_ready), 64'(q.size() < 2));
      acc = b32.in_valid && b32.in_ready && !b32.flush;
      dr  = b32.out_valid && b32.out_ready;
      if (dr && q.size() > 0) begin
        chk("rnd_imm", 64'(b32.out_imm), q[0].imm);
        chk("rnd_fmt", 64'(b32.out_fmt), 64'(q[0].fmt));
        chk("rnd_ill", 64'(b32.out_illegal), 64'(q[0].ill));
        chk("rnd_instr", 64'(b32.out_instr), 64'(q[0].instr));
        chk("rnd_pc", 64'(b32.out_pc), q[0].pc);
      end
      @(posedge clk); #1;
      if (dr && q.size() > 0) void'(q.pop_front());
      if (b32.flush) q.delete();
      else if (acc) begin
        q.push_back(ref_dec(b32.in_instr, 64'(b32.in_pc), 32));
        accepted++;
      end
      cyc++;
    end
    b32.in_valid = 1'b0; b32.flush = 1'b0;
    chk("rnd_completed", 64'(accepted >= 10000), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_decode_stage.md
# imm_decode_stage

Registered instruction-format decode and immediate-extraction stage for the RV32I/RV64I front end, sitting between fetch and register read. It classifies every opcode, builds the immediate for all base formats (I, S, B, U, J, plus shift-amount and CSR forms), flags unsupported opcodes, and passes PC and instruction through. A 2-entry skid buffer with valid/ready handshakes on both sides lets the stage absorb downstream stalls without dropping or duplicating instructions.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64; immediates are sign-extended to XLEN
- SHAMT_W, derived (5 when XLEN=32, 6 when XLEN=64), shift-amount field width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous flush; empties the buffer and drops the input presented in the same cycle
- in_valid  in  1  upstream holds a valid instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_instr  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  output slot holds a decoded instruction
- out_ready  in  1  downstream consumes the output this cycle
- out_imm  out  XLEN  extended immediate
- out_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J
- out_illegal  out  1  opcode is not in the supported set
- out_instr  out  32  pass-through instruction
- out_pc  out  XLEN  pass-through PC

## Operation
- Decode keys on instr[6:0]:
  - LOAD 0000011, MISC-MEM 0001111, JALR 1100111, SYSTEM 1110011 -> I: sext(instr[31:20])
  - OP-IMM 0010011 -> I; when funct3 is 001 or 101, imm = zext(instr[20+SHAMT_W-1:20]); otherwise sext(instr[31:20])
  - STORE 0100011 -> S: sext({instr[31:25],instr[11:7]})
  - BRANCH 1100011 -> B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0})
  - LUI 0110111 and AUIPC 0010111 -> U: sext({instr[31:12],12'b0})
  - JAL 1101111 -> J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0})
  - OP 0110011 -> R: imm=0
  - Any other opcode -> fmt=0, imm=0, illegal=1; the stage still forwards it without stalling
- The decode is computed on the input side and stored with PC and instruction in the buffer entry.
- Buffer states are by occupancy: EMPTY (0), ONE (1), TWO (2); in_ready = (occupancy != TWO) and not rst.
  - Accept = in_valid & in_ready & ~flush; Drain = out_valid & out_ready.
  - EMPTY: accept -> ONE.
  - ONE: accept & ~drain -> TWO; drain & ~accept -> EMPTY; accept & drain -> ONE, with the new entry replacing the head.
  - TWO: drain -> ONE, and the second entry becomes the head. No accept is possible.
- The head entry drives the out_* signals. out_valid = (occupancy != EMPTY).
- Priority is rst > flush > normal. Either rst or flush forces EMPTY on the next edge, and out_data is zeroed.
- Reset values: out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_instr=0, out_pc=0, occupancy EMPTY. in_ready=0 while rst is high and 1 in the first cycle after.
- Output stability: while out_valid=1 and out_ready=0, every out_* signal holds constant.

## Timing
- Latency is 1 cycle. An instruction accepted at edge N appears on out_* after edge N, provided it is the head.
- Throughput is 1 instruction per cycle when out_ready stays high. Occupancy then stays at ONE.
- in_ready is derived from registered occupancy only. There is no combinational path from out_ready to in_ready.
- A stall of any length loses no instructions: at most 2 are held, and in_ready drops when TWO is reached.
- Reset or flush mid-stream discards all buffered entries. A drain in the same cycle as flush is still counted downstream.

## Test plan
- Formats, XLEN=32:
  - 0xFFC12083 (lw) -> imm 0xFFFFFFFC, fmt 1
  - 0xFE112E23 (sw) -> imm 0xFFFFFFFC, fmt 2
  - 0xFE000CE3 (beq -8) -> imm 0xFFFFFFF8, fmt 3
  - 0x123452B7 (lui) -> imm 0x12345000, fmt 4
  - 0x001000EF (jal) -> imm 0x00000800, fmt 5
- Shift and illegal opcode:
  - 0x40315093 (srai x1,x2,3) -> imm 0x3, fmt 1
  - 0x0000007F -> illegal 1, imm 0, out_valid 1
- XLEN=64 extension: 0x800002B7 -> imm 0xFFFFFFFF80000000. Shift 0x03F11093 (slli x1,x2,63) -> imm 63.
- Backpressure:
  - Stream 5 instructions with out_ready=0 for 4 cycles -> in_ready falls after 2 accepts, outputs stay stable.
  - Release out_ready -> all 5 emerge in order, with no duplicates or drops.
- Flush and reset:
  - Assert flush while in TWO with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the input is not delivered.
  - Assert rst mid-stream -> all outputs 0 on the next edge.
- Randomised valid/ready traffic with a scoreboard comparing against a reference decode model -> zero mismatches over 10k instructions.
